apb_arb_manager: RTL and testbench



---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_arb_manager_if.sv | 34 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/apb_arb_manager.sv | 172 +++++++++++++++++
 tb/tb_apb_arb_manager.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB arbitrating manager: FSM state
// encoding and PPROT bit positions.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int ProtWidth  = 4;
    localparam int PROT_PRIV  = 0;
    localparam int PROT_NSEC  = 1;
    localparam int PROT_INSTR = 2;

endpackage

// File: rtl/apb_arb_manager_if.sv
// APB bus bundle between one manager and its completers.
// The manager drives the request side, completers return ready/data/error.
interface apb_arb_manager_if
    import apb_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int PrphNum   = 4
);

    logic [AddrWidth-1:0]   addr;
    logic [ProtWidth-1:0]   prot;
    logic [PrphNum-1:0]     selectors;
    logic                   enable;
    logic                   write;
    logic [DataWidth-1:0]   wData;
    logic [DataWidth/8-1:0] strb;
    logic                   ready;
    logic [DataWidth-1:0]   rData;
    logic                   slvError;

    modport master (
        output addr, prot, selectors, enable,
        output write, wData, strb,
        input  ready, rData, slvError
    );

    modport slave (
        input  addr, prot, selectors, enable,
        input  write, wData, strb,
        output ready, rData, slvError
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the
// pointer (wrapping) and advances the pointer past each grant.
module rr_arbiter #(
    parameter int  ReqNum = 2,
    localparam int PtrW   = (ReqNum > 1) ? $clog2(ReqNum) : 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [ReqNum-1:0] i_req,
    input  logic              i_en,
    output logic [ReqNum-1:0] o_grant,
    output logic [PtrW-1:0]   o_idx,
    output logic              o_any
);

    logic [PtrW-1:0] r_ptr;

    function automatic logic [PtrW-1:0] wrap(input int v);
        return PtrW'(v % ReqNum);
    endfunction

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < ReqNum; k++) begin
            if (!o_any && i_req[wrap(int'(r_ptr) + k)]) begin
                o_any = 1'b1;
                o_idx = wrap(int'(r_ptr) + k);
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_ptr <= '0;
        end else if (i_en && o_any) begin
            r_ptr <= wrap(int'(o_idx) + 1);
        end
    end

endmodule

// File: rtl/apb_arb_manager.sv
// APB manager shared by ReqNum requesters: RR grant, address decode,
// SETUP/ACCESS sequencing. Define APB_TIMEOUT_EN to bound ACCESS waits.
module apb_arb_manager
    import apb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int PrphNum       = 4,
    parameter int ReqNum        = 2,
    parameter int PrphSelLsb    = 12,
    parameter int TimeoutCycles = 16
) (
    input  logic                                  clk,
    input  logic                                  nReset,
    input  logic [ReqNum-1:0]                     reqValid,
    input  logic [ReqNum-1:0][AddrWidth-1:0]      reqAddr,
    input  logic [ReqNum-1:0]                     reqWrite,
    input  logic [ReqNum-1:0][DataWidth-1:0]      reqWData,
    input  logic [ReqNum-1:0][DataWidth/8-1:0]    reqStrb,
    input  logic [ReqNum-1:0][ProtWidth-1:0]      reqProt,
    output logic [ReqNum-1:0]                     reqAck,
    output logic [ReqNum-1:0]                     rspValid,
    output logic [DataWidth-1:0]                  rspRData,
    output logic                                  rspError,
    apb_arb_manager_if.master                     apb
);

    localparam int PtrW = (ReqNum > 1) ? $clog2(ReqNum) : 1;
    localparam int SelW = (PrphNum > 1) ? $clog2(PrphNum) : 1;

    apb_state_e             r_state;
    logic [PtrW-1:0]        r_gidx;
    logic [AddrWidth-1:0]   r_addr;
    logic [ProtWidth-1:0]   r_prot;
    logic [PrphNum-1:0]     r_sel;
    logic                   r_en;
    logic                   r_write;
    logic [DataWidth-1:0]   r_wdata;
    logic [DataWidth/8-1:0] r_strb;
    logic [ReqNum-1:0]      r_rspv;
    logic [DataWidth-1:0]   r_rdata;
    logic                   r_err;

    logic [ReqNum-1:0]      w_grant;
    logic [PtrW-1:0]        w_gidx;
    logic                   w_any;
    logic                   w_idle;
    logic [SelW-1:0]        w_sel;
    logic                   w_dec_ok;

`ifdef APB_TIMEOUT_EN
    localparam int ToW = $clog2(TimeoutCycles + 1);
    logic [ToW-1:0]         r_wait;
`endif

    assign w_idle = (r_state == IDLE);

    rr_arbiter #(
        .ReqNum (ReqNum)
    ) u_arb (
        .clk     (clk),
        .nReset  (nReset),
        .i_req   (reqValid),
        .i_en    (w_idle),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // Non-power-of-two PrphNum leaves index codes with no completer
    assign w_sel    = reqAddr[w_gidx][PrphSelLsb +: SelW];
    assign w_dec_ok = int'(w_sel) < PrphNum;

    // Ack is combinational so the grant cycle precedes SETUP
    assign reqAck = (w_idle && nReset) ? w_grant : '0;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_gidx  <= '0;
            r_addr  <= '0;
            r_prot  <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_rspv  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_wait  <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gidx <= w_gidx;
                        if (w_dec_ok) begin
                            r_addr  <= reqAddr[w_gidx];
                            r_prot  <= reqProt[w_gidx];
                            r_write <= reqWrite[w_gidx];
                            r_wdata <= reqWrite[w_gidx] ?
                                       reqWData[w_gidx] : '0;
                            r_strb  <= reqWrite[w_gidx] ?
                                       reqStrb[w_gidx] : '0;
                            r_sel   <= PrphNum'(1) << w_sel;
                            r_en    <= 1'b0;
                            r_state <= SETUP;
                        end else begin
                            r_rspv  <= w_grant;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= RESP;
                        end
                    end
                end
                SETUP: begin
                    r_en    <= 1'b1;
                    r_state <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_wait  <= '0;
`endif
                end
                ACCESS: begin
                    if (apb.ready) begin
                        r_sel   <= '0;
                        r_en    <= 1'b0;
                        r_rspv  <= ReqNum'(1) << r_gidx;
                        r_err   <= apb.slvError;
                        r_rdata <= (!r_write && !apb.slvError) ?
                                   apb.rData : '0;
                        r_state <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_wait == ToW'(TimeoutCycles - 1)) begin
                        r_sel   <= '0;
                        r_en    <= 1'b0;
                        r_rspv  <= ReqNum'(1) << r_gidx;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= RESP;
                    end else begin
                        r_wait  <= r_wait + 1'b1;
                    end
`endif
                end
                RESP: begin
                    r_rspv  <= '0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rspValid      = r_rspv;
    assign rspRData      = r_rdata;
    assign rspError      = r_err;
    assign apb.addr      = r_addr;
    assign apb.prot      = r_prot;
    assign apb.selectors = r_sel;
    assign apb.enable    = r_en;
    assign apb.write     = r_write;
    assign apb.wData     = r_wdata;
    assign apb.strb      = r_strb;

endmodule

// File: tb/tb_apb_arb_manager.sv
// Bench for apb_arb_manager: transaction model builds per-cycle
// expectations, a negedge process compares them against the DUT.
module tb_apb_arb_manager;
    import apb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int PN  = 3;
    localparam int RN  = 2;
    localparam int LSB = 12;
    localparam int TO  = 16;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    typedef struct packed {
        logic        z;
        logic [1:0]  ack;
        logic [2:0]  sel;
        logic        en;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [3:0]  prot;
        logic [1:0]  rspv;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                nReset;
    logic [1:0]          reqValid;
    logic [1:0][31:0]    reqAddr;
    logic [1:0]          reqWrite;
    logic [1:0][31:0]    reqWData;
    logic [1:0][3:0]     reqStrb;
    logic [1:0][3:0]     reqProt;
    logic [1:0]          reqAck;
    logic [1:0]          rspValid;
    logic [31:0]         rspRData;
    logic                rspError;

    apb_arb_manager_if #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .PrphNum   (PN)
    ) bus ();

    apb_arb_manager #(
        .AddrWidth     (AW),
        .DataWidth     (DW),
        .PrphNum       (PN),
        .ReqNum        (RN),
        .PrphSelLsb    (LSB),
        .TimeoutCycles (TO)
    ) dut (
        .clk      (clk),
        .nReset   (nReset),
        .reqValid (reqValid),
        .reqAddr  (reqAddr),
        .reqWrite (reqWrite),
        .reqWData (reqWData),
        .reqStrb  (reqStrb),
        .reqProt  (reqProt),
        .reqAck   (reqAck),
        .rspValid (rspValid),
        .rspRData (rspRData),
        .rspError (rspError),
        .apb      (bus)
    );

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_ptr = 0;
    int          ack_log[$];
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;
    int          g;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t",
                     nm, act, want, $time);
        end
    endfunction

    // Model: arbitration order and decode from the rules
    function automatic int pick(input logic [1:0] pend);
        for (int k = 0; k < RN; k++) begin
            int c;
            c = (m_ptr + k) % RN;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    function automatic int dec_idx(input logic [31:0] a);
        return int'((a >> LSB) & 32'h3);
    endfunction

    function automatic exp_t e_idle();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t e_zero();
        exp_t e;
        e = '0;
        e.z = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_ack(input int gi);
        exp_t e;
        e = '0;
        e.ack = 2'(1 << gi);
        return e;
    endfunction

    function automatic exp_t e_bus(input int gi, input int idx,
                                   input logic en);
        exp_t e;
        e = '0;
        e.sel  = 3'(1 << idx);
        e.en   = en;
        e.addr = reqAddr[gi];
        e.wr   = reqWrite[gi];
        e.wd   = reqWrite[gi] ? reqWData[gi] : 32'h0;
        e.strb = reqWrite[gi] ? reqStrb[gi] : 4'h0;
        e.prot = reqProt[gi];
        return e;
    endfunction

    function automatic exp_t e_resp(input int gi, input logic err,
                                    input logic [31:0] rd);
        exp_t e;
        e = '0;
        e.rspv = 2'(1 << gi);
        e.err  = err;
        e.rd   = rd;
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("reqAck", 32'(reqAck), 32'(cur.ack));
            chk("selectors", 32'(bus.selectors), 32'(cur.sel));
            chk("enable", 32'(bus.enable), 32'(cur.en));
            chk("rspValid", 32'(rspValid), 32'(cur.rspv));
            if (cur.sel != 0 || cur.z) begin
                chk("addr", bus.addr, cur.addr);
                chk("write", 32'(bus.write), 32'(cur.wr));
                chk("wData", bus.wData, cur.wd);
                chk("strb", 32'(bus.strb), 32'(cur.strb));
                chk("prot", 32'(bus.prot), 32'(cur.prot));
            end
            if (cur.rspv != 0 || cur.z) begin
                chk("rspError", 32'(rspError), 32'(cur.err));
                chk("rspRData", rspRData, cur.rd);
            end
            if (reqAck != 0) ack_log.push_back(reqAck[1] ? 1 : 0);
            if (rspValid != 0) begin
                last_rd  = rspRData;
                last_err = rspError;
            end
        end
    end

    task automatic step(input exp_t e, input logic [1:0] v,
                        input logic rdy, input logic [31:0] rd,
                        input logic se, input logic rn);
        @(posedge clk);
        #1;
        nReset        = rn;
        reqValid      = v;
        bus.ready     = rdy;
        bus.rData     = rd;
        bus.slvError  = se;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(e_idle(), 2'b00, 1'b0, JUNK, 1'b1, 1'b1);
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic w, input logic [31:0] wd,
                           input logic [3:0] s, input logic [3:0] p);
        reqAddr[i]  = a;
        reqWrite[i] = w;
        reqWData[i] = wd;
        reqStrb[i]  = s;
        reqProt[i]  = p;
    endtask

    // One arbitration round; abort_at >= 0 resets in that ACCESS cycle
    task automatic round(input logic [1:0] pend, input int waits,
                         input bit tmo, input logic [31:0] rd,
                         input bit se, input int abort_at,
                         output int g_o);
        int gi, idx, n_acc;
        logic rdy;
        gi    = pick(pend);
        m_ptr = (gi + 1) % RN;
        g_o   = gi;
        idx   = dec_idx(reqAddr[gi]);
        step(e_ack(gi), pend, 1'b0, JUNK, 1'b1, 1'b1);
        if (idx >= PN) begin
            step(e_resp(gi, 1'b1, 32'h0), pend, 1'b0, JUNK, 1'b1, 1'b1);
            return;
        end
        step(e_bus(gi, idx, 1'b0), pend, 1'b0, JUNK, 1'b1, 1'b1);
        n_acc = tmo ? TO : waits + 1;
        for (int j = 0; j < n_acc; j++) begin
            if (j == abort_at) begin
                step(e_zero(), 2'b11, 1'b0, JUNK, 1'b1, 1'b0);
                step(e_zero(), 2'b11, 1'b1, JUNK, 1'b1, 1'b0);
                step(e_idle(), 2'b00, 1'b0, JUNK, 1'b1, 1'b1);
                m_ptr = 0;
                return;
            end
            rdy = !tmo && (j == waits);
            step(e_bus(gi, idx, 1'b1), pend, rdy,
                 rdy ? rd : JUNK, rdy ? se : 1'b1, 1'b1);
        end
        step(e_resp(gi, tmo || se,
                    (tmo || se || reqWrite[gi]) ? 32'h0 : rd),
             pend, 1'b1, JUNK, 1'b1, 1'b1);
    endtask

    initial begin
        nReset       = 1'b0;
        reqValid     = 2'b00;
        reqAddr      = '0;
        reqWrite     = '0;
        reqWData     = '0;
        reqStrb      = '0;
        reqProt      = '0;
        bus.ready    = 1'b0;
        bus.rData    = '0;
        bus.slvError = 1'b0;

        // Reset with both requests asserted: everything must stay 0
        repeat (3) step(e_zero(), 2'b11, 1'b1, JUNK, 1'b1, 1'b0);
        idle(2);

        set_req(0, 32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 4'hF,
                4'(1 << PROT_PRIV));
        chk("model_idx_2004", 32'(dec_idx(32'h0000_2004)), 32'd2);
        chk("model_sel_2004", 32'(e_bus(0, 2, 1'b0).sel), 32'h4);
        round(2'b01, 0, 1'b0, 32'h0, 1'b0, -1, g);
        chk("model_first_grant", 32'(g), 32'd0);
        idle(2);
        chk("write_rsp_err", 32'(last_err), 32'd0);

        set_req(1, 32'h0000_1008, 1'b0, 32'hCAFE_F00D, 4'hA,
                4'(1 << PROT_NSEC));
        round(2'b10, 3, 1'b0, 32'h1234_5678, 1'b0, -1, g);
        idle(2);
        chk("read_wait_grant", 32'(g), 32'd1);
        chk("read_wait_rdata", last_rd, 32'h1234_5678);

        set_req(0, 32'h0000_3000, 1'b1, 32'h1111_2222, 4'h3, 4'h0);
        round(2'b01, 0, 1'b0, 32'h0, 1'b0, -1, g);
        idle(2);
        chk("decode_err", 32'(last_err), 32'd1);

        set_req(1, 32'h0000_0000, 1'b0, 32'h0, 4'h0,
                4'(1 << PROT_INSTR));
        round(2'b10, 1, 1'b0, 32'hFFFF_0000, 1'b1, -1, g);
        idle(2);
        chk("slverr_rdata", last_rd, 32'h0);
        chk("slverr_err", 32'(last_err), 32'd1);

        set_req(0, 32'h0000_2100, 1'b1, 32'hA5A5_5A5A, 4'h6, 4'h5);
        round(2'b01, 2, 1'b0, 32'h0, 1'b0, -1, g);
        idle(1);

        set_req(1, 32'h0000_0040, 1'b0, 32'h0, 4'h0, 4'h0);
`ifdef APB_TIMEOUT_EN
        round(2'b10, 0, 1'b1, 32'h7777_7777, 1'b0, -1, g);
        idle(2);
        chk("timeout_err", 32'(last_err), 32'd1);
        chk("timeout_rdata", last_rd, 32'h0);
`else
        round(2'b10, 20, 1'b0, 32'h5555_AAAA, 1'b0, -1, g);
        idle(2);
        chk("long_wait_rdata", last_rd, 32'h5555_AAAA);
`endif

        set_req(0, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 4'h0);
        round(2'b01, 5, 1'b0, 32'h9999_9999, 1'b0, 3, g);
        idle(1);

        set_req(0, 32'h0000_0010, 1'b1, 32'h0BAD_F00D, 4'hC, 4'h2);
        set_req(1, 32'h0000_2020, 1'b0, 32'h0, 4'h0, 4'h0);
        ack_log.delete();
        round(2'b11, 0, 1'b0, 32'h0, 1'b0, -1, g);
        round(2'b11, 1, 1'b0, 32'h600D_0001, 1'b0, -1, g);
        round(2'b11, 0, 1'b0, 32'h0, 1'b0, -1, g);
        round(2'b11, 2, 1'b0, 32'h600D_0002, 1'b0, -1, g);
        idle(3);
        chk("contend_count", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_log.size())
                chk("contend_order", 32'(ack_log[i]), 32'(i % 2));
        end
        chk("contend_last_rdata", last_rd, 32'h600D_0002);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
